// File: rtl/load_store_unit.sv
// Load/store unit: bridges the MEM stage to a handshaked data-memory bus.
// Builds byte enables and lane-replicated store data, extends sub-word loads,
// stalls the pipeline while an access is in flight, and flags misaligned
// requests and bus timeouts.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no access; accepts an aligned request, rejects a misaligned one
// S_REQ  | bus_req_o asserted, waiting for bus_gnt_i
// S_WAIT | load granted, waiting for bus_rvalid_i
// S_DONE | one-cycle completion (done_o, optional err_o), back to S_IDLE
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    // Timeout fires on the last allowed REQ/WAIT cycle (counter starts at 0).
    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_nxt;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q, off_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [7:0]  cnt_q;

    logic        misaligned, idle_req, accept, busy, timeout, gnt_hit, rv_hit;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, lane, ld_ext;

    // Request decode: alignment check, byte enables, replicated store data.
    always_comb begin
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = wdata_i;
        case (size_i)
            2'b00: begin
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = addr_i[0];
                be_new     = 4'b0011 << addr_i[1:0];
                wdata_new  = {2{wdata_i[15:0]}};
            end
            2'b10:   misaligned = |addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Qualifiers shared by FSM and datapath. Gating the IDLE terms with rst
    // lets stall/misalign fall as soon as reset is asserted.
    assign idle_req = (state_q == S_IDLE) && req_valid_i && rst;
    assign accept   = idle_req && !misaligned;
    assign busy     = (state_q == S_REQ) || (state_q == S_WAIT);
    assign timeout  = busy && (cnt_q >= TC_LAST);
    assign gnt_hit  = (state_q == S_REQ) && bus_gnt_i;
    assign rv_hit   = (state_q == S_WAIT) && bus_rvalid_i;

    // Load lane select and sign/zero extension.
    always_comb begin
        lane = bus_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
            2'b01:   ld_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_nxt;
    end

    // Next-state logic; a handshake in the timeout cycle wins over the timeout.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if (accept) state_nxt = S_REQ;
            S_REQ: begin
                if (gnt_hit)      state_nxt = we_q ? S_DONE : S_WAIT;
                else if (timeout) state_nxt = S_DONE;
            end
            S_WAIT:  if (rv_hit || timeout) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        stall_o     = accept || busy;
        misalign_o  = idle_req && misaligned;
        done_o      = (state_q == S_DONE);
        err_o       = (state_q == S_DONE) && err_q;
        bus_req_o   = (state_q == S_REQ);
        bus_we_o    = bus_req_o && we_q;
        bus_addr_o  = bus_req_o ? addr_q  : 32'h0;
        bus_be_o    = bus_req_o ? be_q    : 4'h0;
        bus_wdata_o = bus_req_o ? wdata_q : 32'h0;
    end

    // Access registers, timeout counter and load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 8'h0;
            err_q   <= 1'b0;
            rdata_o <= 32'h0;
        end else if (accept) begin
            we_q    <= we_i;
            uns_q   <= unsigned_i;
            size_q  <= size_i;
            off_q   <= addr_i[1:0];
            addr_q  <= {addr_i[31:2], 2'b00};
            be_q    <= be_new;
            wdata_q <= wdata_new;
            cnt_q   <= 8'h0;
            err_q   <= 1'b0;
        end else if (busy) begin
            cnt_q <= cnt_q + 8'd1;
            if (rv_hit) begin
                rdata_o <= ld_ext;
            end else if (timeout && !gnt_hit) begin
                rdata_o <= 32'h0;
                err_q   <= 1'b1;
            end
        end else if (state_q == S_DONE) begin
            err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus randomized accesses,
// each checked cycle by cycle against a transaction-level reference model.
module tb_load_store_unit;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, we_i, unsigned_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, misalign_o, err_o;
    logic [31:0] rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = 32'h0;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .misalign_o(misalign_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=0x%08h exp=0x%08h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_misaligned(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        if (size == 2'b11) return 1'b1;
        nb = 1 << size;
        return (int'(addr[1:0]) % nb) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        int nb, m;
        nb = 1 << size;
        m  = ((1 << nb) - 1) << int'(addr[1:0]);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
        if (size == 2'b00) return wdata[7:0] * 32'h01010101;
        if (size == 2'b01) return wdata[15:0] * 32'h00010001;
        return wdata;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] word);
        longint v, one;
        int     nbits;
        one   = 1;
        nbits = 8 << size;
        v     = {32'b0, word};
        v     = v >> (8 * int'(off));
        if (nbits < 32) begin
            v = v % (one << nbits);
            if (!uns && v >= (one << (nbits - 1))) v = v - (one << nbits);
        end
        return v[31:0];
    endfunction

    // One access. g = REQ cycles without grant before gnt, r = WAIT cycles
    // without rvalid before rvalid. Starts and ends just after a rising edge.
    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int g, input int r, input logic [31:0] word);
        int          req_end, done_c, rv_c, lim;
        bit          tmo;
        logic [31:0] nrd;
        req_valid_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns;
        addr_i = addr; wdata_i = wdata; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        if (is_misaligned(size, addr)) begin
            #1;
            chk("mis_flag", 32'(misalign_o), 32'd1);
            chk("mis_stall", 32'(stall_o), 32'd0);
            chk("mis_bus_req", 32'(bus_req_o), 32'd0);
            @(posedge clk); #1;
            req_valid_i = 1'b0;
            #1;
            chk("mis_pulse", 32'(misalign_o), 32'd0);
            chk("mis_idle_req", 32'(bus_req_o), 32'd0);
            chk("mis_idle_stall", 32'(stall_o), 32'd0);
            @(posedge clk); #1;
            return;
        end
        rv_c = g + r + 2;
        if (g <= T - 1) begin
            req_end = g + 1;
            if (we) begin
                tmo = 1'b0; done_c = g + 2;
            end else begin
                lim = (T - 1 > g + 1) ? T - 1 : g + 1;
                if (g + 1 + r <= lim) begin tmo = 1'b0; done_c = g + r + 3; end
                else                  begin tmo = 1'b1; done_c = lim + 2;   end
            end
        end else begin
            req_end = T; tmo = 1'b1; done_c = T + 1;
        end
        nrd = tmo ? 32'h0 : (we ? exp_rdata : model_load(size, uns, addr[1:0], word));
        for (int c = 0; c <= done_c; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            bus_gnt_i    = (c == g + 1);
            bus_rvalid_i = !we && (c == rv_c);
            bus_rdata_i  = (c == rv_c) ? word : $urandom;
            #1;
            if (c == 0) chk("rdata_hold", rdata_o, exp_rdata);
            chk("stall", 32'(stall_o), 32'(c < done_c));
            chk("done", 32'(done_o), 32'(c == done_c));
            chk("bus_req", 32'(bus_req_o), 32'(c >= 1 && c <= req_end));
            chk("err", 32'(err_o), 32'(tmo && c == done_c));
            if (c >= 1 && c <= req_end) begin
                chk("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
                chk("bus_be", 32'(bus_be_o), 32'(model_be(size, addr)));
                chk("bus_wdata", bus_wdata_o, model_wdata(size, wdata));
                chk("bus_we", 32'(bus_we_o), 32'(we));
            end
            if (c == done_c) begin
                exp_rdata = nrd;
                chk("rdata", rdata_o, exp_rdata);
            end
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    endtask

    // Reset asserted mid-access (phase 1: in REQ, phase 2: in WAIT).
    task automatic reset_mid(input int phase);
        req_valid_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0;
        addr_i = 32'h300; wdata_i = 32'h0;
        @(posedge clk); #1;
        bus_gnt_i = (phase == 2);
        if (phase == 2) begin @(posedge clk); #1; bus_gnt_i = 1'b0; end
        #1;
        chk("rst_pre_stall", 32'(stall_o), 32'd1);
        rst = 1'b0;
        #1;
        exp_rdata = 32'h0;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_rdata", rdata_o, exp_rdata);
        #1;
        rst = 1'b1; req_valid_i = 1'b0;
        @(posedge clk); #1;
        bus_rvalid_i = 1'b1; bus_gnt_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
        #1;
        chk("late_done", 32'(done_o), 32'd0);
        chk("late_stall", 32'(stall_o), 32'd0);
        chk("late_bus_req", 32'(bus_req_o), 32'd0);
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0; bus_gnt_i = 1'b0;
        #1;
        chk("late_done2", 32'(done_o), 32'd0);
        chk("late_rdata", rdata_o, exp_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rwe, runs;
        logic [1:0]  rsize;
        logic [31:0] raddr;
        int          rg, rr;
        rst = 1'b0; req_valid_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        bus_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_bus_req", 32'(bus_req_o), 32'd0);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_misalign", 32'(misalign_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        @(posedge clk); #1;

        access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
        access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80FF0000);
        access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 0, 32'h80FF0000);
        access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 0, 32'h80FF0000);
        access(1'b1, 2'b00, 1'b0, 32'h201, 32'h12345678, 0, 0, 32'h0);
        access(1'b1, 2'b01, 1'b0, 32'h202, 32'h12345678, 0, 0, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 0, 32'h0);
        access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 0, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h140, 32'h0, 5, 1, 32'h13579BDF);
        reset_mid(2);
        access(1'b0, 2'b10, 1'b0, 32'h180, 32'h0, 0, 0, 32'h2468ACE0);
        reset_mid(1);
        access(1'b0, 2'b01, 1'b1, 32'h1C2, 32'h0, 1, 0, 32'hA5A5F00F);
        access(1'b1, 2'b10, 1'b0, 32'h400, 32'hFEEDFACE, 30, 0, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 30, 0, 32'h11111111);
        access(1'b1, 2'b10, 1'b0, 32'h408, 32'h0BADF00D, T - 1, 0, 32'h0);
        access(1'b1, 2'b10, 1'b0, 32'h40C, 32'h0BADF00D, T, 0, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h410, 32'h0, T - 1, 0, 32'h77777777);
        access(1'b0, 2'b00, 1'b0, 32'h411, 32'h0, 3, T - 5, 32'h0000C300);
        access(1'b0, 2'b00, 1'b0, 32'h411, 32'h0, 3, T - 4, 32'h0000C300);

        for (int i = 0; i < 300; i++) begin
            rwe   = 1'($urandom_range(0, 1));
            runs  = 1'($urandom_range(0, 1));
            rsize = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0 && rsize != 2'b11)
                raddr = raddr & ~((32'd1 << rsize) - 32'd1);
            rg = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
            rr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 3));
            access(rwe, rsize, runs, raddr, $urandom, rg, rr, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the pipeline's MEM stage and a handshaked data-memory bus, replacing the single-cycle data-memory port. Generates byte enables and replicated write data, and sign- or zero-extends sub-word loads. Stalls the pipeline while an access is outstanding, and reports misaligned accesses and bus timeouts.

## Interface
- TIMEOUT_CYCLES, 15: maximum cycles spent in REQ+WAIT before the access is aborted (range 1..255).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  MEM stage holds a load or store.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
- unsigned_i  in  1  zero-extend loads (LBU/LHU).
- addr_i  in  32  byte address (ALU result).
- wdata_i  in  32  store data (rs2).
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- done_o  out  1  one-cycle pulse: access complete, rdata_o valid.
- rdata_o  out  32  extended load data; held until next done_o.
- misalign_o  out  1  one-cycle flag: misaligned or reserved-size request rejected.
- err_o  out  1  one-cycle flag coincident with done_o on timeout.
- bus_req_o  out  1  request; held until bus_gnt_i.
- bus_we_o  out  1  write strobe.
- bus_addr_o  out  32  word address ({addr[31:2],2'b00}).
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  lane-replicated store data.
- bus_gnt_i  in  1  request accepted this cycle.
- bus_rvalid_i  in  1  read data valid; never earlier than the cycle after gnt.
- bus_rdata_i  in  32  read word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset → IDLE, all outputs 0, rdata_o = 0, counter 0.
- Misalignment check: half with addr_i[0]=1; word with addr_i[1:0]≠0; size_i=11 is always rejected.
- IDLE, req_valid_i=1, misaligned: misalign_o=1 combinationally, stall_o=0, no bus activity, stay in IDLE.
- IDLE, req_valid_i=1, aligned: stall_o=1 combinationally. Latch we, size, unsigned, addr[1:0], word address, BE and write data, then → REQ.
- BE: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Write data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- REQ: bus_req_o=1 with addr, we, be and wdata stable. On bus_gnt_i, deassert bus_req_o next cycle; store → DONE, load → WAIT.
- WAIT: on bus_rvalid_i, select the lane by the latched addr[1:0] and extend per size/unsigned, register the result into rdata_o, then → DONE.
- Stores leave rdata_o unchanged.
- Timeout counter: cleared on IDLE→REQ; increments every cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES:
  - drop bus_req_o
  - set rdata_o = 0
  - → DONE with err_o=1.
- A gnt or rvalid arriving in the same cycle as the timeout takes priority over the timeout.
- DONE: stall_o=0, done_o=1; the pipeline advances at this edge. req_valid_i is ignored; → IDLE unconditionally.
- stall_o = 1 for (IDLE & req_valid_i & aligned) | REQ | WAIT.
- bus_rvalid_i outside WAIT and bus_gnt_i outside REQ are ignored.
- Reset asserted mid-access: bus_req_o and stall_o drop immediately (asynchronously), FSM → IDLE. An in-flight bus response is discarded.

## Timing
- Load, gnt in first REQ cycle, rvalid one cycle later:
  - C0 IDLE accept (stall=1)
  - C1 REQ (gnt)
  - C2 WAIT (rvalid)
  - C3 DONE (done=1, stall=0)
  - Total: 3 stall cycles.
- Store, immediate gnt: C0 IDLE, C1 REQ, C2 DONE. Total: 2 stall cycles.
- Each extra gnt or rvalid wait cycle adds one stall cycle.
- Timeout: DONE occurs TIMEOUT_CYCLES+1 cycles after accept.
- Back-to-back accesses: the next access is accepted in the IDLE cycle right after DONE. Minimum spacing is 4 cycles per load.
- misalign_o, done_o and err_o are single-cycle pulses.

## Test plan
- Word load at 0x100, gnt immediate, rvalid next with 0xDEADBEEF → rdata_o=0xDEADBEEF at C3, done_o one cycle, stall high C0–C2.
- LB at 0x103, bus word 0x80FF_0000 → rdata_o=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB at 0x201 with wdata 0x12345678 → bus_be_o=0010, bus_wdata_o=0x78787878, bus_addr_o=0x200. SH at 0x202 → be=1100, wdata=0x56785678.
- LW at 0x102 → misalign_o=1, stall_o=0, bus_req_o never asserted. size_i=11 gives the same response.
- gnt withheld for 5 cycles then given, rvalid after 2 more → bus_req_o high exactly 6 cycles, done_o 9 cycles after accept, rdata correct.
- No gnt with TIMEOUT_CYCLES=15 → err_o and done_o at cycle 16, rdata_o=0, bus_req_o low. A further case asserts reset in WAIT: outputs 0 immediately, FSM idle, and a late rvalid is ignored.
